uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter. It accepts a parallel byte from the upstream interface and latches it together with its parity configuration. It sequences start, data (LSB first), optional parity and stop bits onto the serial line. It feeds the parity calculator (latched data, enable, type) and consumes the calculator's combinational parity bit during the parity slot. It runs on the TX bit clock: one serial bit per clock cycle.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
CNT_W, $clog2(DATA_WIDTH), width of the data-bit counter; derived, not overridden.

Ports:
CLK  input  1  TX bit clock; one serial bit per rising edge.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  parallel byte to send.
Data_Valid  input  1  single-cycle strobe; P_DATA, PAR_EN and PAR_TYP are valid in this cycle.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  1 = odd parity, 0 = even parity.
PAR_bit  input  1  parity result returned from the parity calculator.
P_DATA_lat  output  DATA_WIDTH  latched byte driven to the parity calculator.
PAR_TYP_lat  output  1  latched parity type driven to the parity calculator.
PAR_Calc_en  output  1  parity calculator enable.
TX_OUT  output  1  serial line; idle level is 1.
Busy  output  1  high while a frame is in flight.

Behaviour:
- All outputs are registered.
- Reset values: TX_OUT=1, Busy=0, PAR_Calc_en=0, P_DATA_lat=0, PAR_TYP_lat=0. State=IDLE, counter=0.
- Reset is asynchronous: asserting RST mid-frame aborts immediately. TX_OUT returns to 1 with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP. Encodings live in the shared package.
- IDLE: TX_OUT=1, Busy=0.
  - On an edge with Data_Valid=1: latch P_DATA, PAR_EN and PAR_TYP; go to START.
- START: TX_OUT=0, Busy=1, PAR_Calc_en=1. Next state is DATA with counter=0.
- DATA: TX_OUT=P_DATA_lat[counter], counter increments every cycle.
  - When counter reaches DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else to STOP.
  - The counter resets to 0 on leaving DATA; it never wraps inside DATA.
- PARITY: TX_OUT is the PAR_bit value sampled on the edge entering this state. Next state is STOP.
- STOP: TX_OUT=1. Next state is IDLE.
  - Busy and PAR_Calc_en fall on the edge leaving STOP.
- Latency: the edge that samples Data_Valid in IDLE produces the start bit on TX_OUT in the following cycle.
- Frame length is 10 cycles with parity off, 11 with parity on (for DATA_WIDTH=8).
- Data_Valid while Busy=1, or in the final STOP cycle, is ignored. No queuing; upstream must wait for Busy=0.
- Back-to-back frames: Data_Valid in the first IDLE cycle after STOP is accepted. This gives a minimum of one idle (1) cycle between frames.
- Changes on P_DATA, PAR_EN or PAR_TYP after acceptance do not affect the frame in flight.
- PAR_Calc_en stays high from START through STOP, so PAR_bit is stable before it is sampled.
- With PAR_Calc_en low, the parity calculator's output is don't-care and is never sampled.

Decomposition:
- Shared package uart_tx_pkg holds:
  - state enum/localparams (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - line constants TX_IDLE=1'b1, TX_START=1'b0, TX_STOP=1'b1.
- One natural sub-module: uart_tx_serializer.
  - Contents: the data-bit counter and bit select.
  - Inputs: load, shift enable, P_DATA_lat.
  - Outputs: ser_bit, ser_done at the last bit.
  - The FSM and the output mux stay in uart_tx_ctrl.

Test Plan:
- Reset: hold RST=0 for 3 cycles, release -> TX_OUT=1, Busy=0, PAR_Calc_en=0. No TX activity with Data_Valid=0 for 20 cycles.
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). Busy high for exactly 11 cycles.
- P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 (odd) -> data bits 1,0,0,0,0,0,0,0, parity bit 0, then stop 1.
- P_DATA=8'hFF, PAR_EN=0 -> 0,1×8,1 (10-cycle frame), no parity slot. PAR_Calc_en still high for the 10 busy cycles.
- Data_Valid pulsed with 8'h3C at cycle 4 of a frame carrying 8'hC3 -> only 8'hC3 is transmitted, 8'h3C is dropped. A new Data_Valid one cycle after Busy falls starts a fresh frame.
- RST pulsed low during the 5th data bit -> TX_OUT=1 and Busy=0 asynchronously, before the next clock edge. The next Data_Valid produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame states and serial line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit counter and bit select for the UART transmitter.
// o_serBit is the bit that goes on the line after the coming clock edge.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_serBit,
  output logic                  o_serDone
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextIdx;

  // r_cnt indexes the bit currently on the line; load points the next edge at bit 0.
  always_comb begin
    w_nextIdx = i_load ? '0 : r_cnt + CNT_W'(1);
    o_serBit  = i_data[w_nextIdx];
    o_serDone = i_shift && (r_cnt == CNT_W'(DATA_WIDTH - 1));
  end

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_cnt <= '0;
    end else if (i_load || o_serDone) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop.
// Every output is registered, so each state's line value is loaded on the edge entering it.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  PAR_bit,
  output logic [DATA_WIDTH-1:0] P_DATA_lat,
  output logic                  PAR_TYP_lat,
  output logic                  PAR_Calc_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_e r_state;
  logic   r_parEnLat;
  logic   w_load;
  logic   w_shift;
  logic   w_serBit;
  logic   w_serDone;

  always_comb begin
    w_load  = (r_state == START);
    w_shift = (r_state == DATA);
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .i_clk    (CLK),
    .i_rstN   (RST),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_data   (P_DATA_lat),
    .o_serBit (w_serBit),
    .o_serDone(w_serDone)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_parEnLat  <= 1'b0;
      P_DATA_lat  <= '0;
      PAR_TYP_lat <= 1'b0;
      PAR_Calc_en <= 1'b0;
      TX_OUT      <= TX_IDLE;
      Busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          TX_OUT <= TX_IDLE;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            P_DATA_lat  <= P_DATA;
            r_parEnLat  <= PAR_EN;
            PAR_TYP_lat <= PAR_TYP;
            PAR_Calc_en <= 1'b1;
            Busy        <= 1'b1;
            TX_OUT      <= TX_START;
            r_state     <= START;
          end
        end
        START: begin
          TX_OUT  <= w_serBit;
          r_state <= DATA;
        end
        DATA: begin
          if (!w_serDone) begin
            TX_OUT <= w_serBit;
          end else if (r_parEnLat) begin
            TX_OUT  <= PAR_bit;
            r_state <= PARITY;
          end else begin
            TX_OUT  <= TX_STOP;
            r_state <= STOP;
          end
        end
        PARITY: begin
          TX_OUT  <= TX_STOP;
          r_state <= STOP;
        end
        STOP: begin
          TX_OUT      <= TX_IDLE;
          Busy        <= 1'b0;
          PAR_Calc_en <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          TX_OUT      <= TX_IDLE;
          Busy        <= 1'b0;
          PAR_Calc_en <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frame table, mid-frame reset and a
// randomised run against a frame-level reference model.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          PAR_bit;
  logic [DW-1:0] P_DATA_lat;
  logic          PAR_TYP_lat;
  logic          PAR_Calc_en;
  logic          TX_OUT;
  logic          Busy;
  logic          parJunk = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        parEn;
    logic        parTyp;
    int          len;
    logic [0:10] seq;
    int          dropAt;
  } vec_t;

  vec_t vecs[6];
  bit   modelQ[$];

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PAR_bit    (PAR_bit),
    .P_DATA_lat (P_DATA_lat),
    .PAR_TYP_lat(PAR_TYP_lat),
    .PAR_Calc_en(PAR_Calc_en),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Parity calculator stand-in; its output is junk whenever it is disabled.
  assign PAR_bit = PAR_Calc_en ? (^P_DATA_lat ^ PAR_TYP_lat) : parJunk;

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic scrambleInputs();
    P_DATA  = 8'($urandom);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    parJunk = 1'($urandom);
  endtask

  // Sends one frame starting in an idle cycle and checks every serial bit.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    checkOutput({v.name, "_preBusy"}, Busy, 0);
    checkOutput({v.name, "_preTx"}, TX_OUT, 1);
    Data_Valid = 1'b1;
    P_DATA     = v.data;
    PAR_EN     = v.parEn;
    PAR_TYP    = v.parTyp;
    for (int i = 0; i < v.len; i++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      scrambleInputs();
      if (i == v.dropAt) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h3C;
      end
      checkOutput($sformatf("%s_tx%0d", v.name, i), TX_OUT, v.seq[i]);
      checkOutput($sformatf("%s_busy%0d", v.name, i), Busy, 1);
      checkOutput($sformatf("%s_calcEn%0d", v.name, i), PAR_Calc_en, 1);
      checkOutput($sformatf("%s_lat%0d", v.name, i), P_DATA_lat, v.data);
    end
    Data_Valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rData;
    logic       rEn, rTyp, rDv, accept, expTx, expBusy;
    logic [7:0] latData;
    logic       latTyp;
    int         ones;

    vecs[0] = '{"a5Even",   8'hA5, 1'b1, 1'b0, 11, 11'b01010010101, -1};
    vecs[1] = '{"x01Odd",   8'h01, 1'b1, 1'b1, 11, 11'b01000000001, -1};
    vecs[2] = '{"ffNoPar",  8'hFF, 1'b0, 1'b0, 10, 11'b01111111110, -1};
    vecs[3] = '{"c3Drop",   8'hC3, 1'b0, 1'b0, 10, 11'b01100001110,  3};
    vecs[4] = '{"x3cOddSt", 8'h3C, 1'b1, 1'b1, 11, 11'b00011110011, 10};
    vecs[5] = '{"c3Even",   8'hC3, 1'b1, 1'b0, 11, 11'b01100001101, -1};

    // Reset held for three cycles, then a quiet line.
    repeat (3) @(negedge CLK);
    checkOutput("rst_tx", TX_OUT, 1);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_calcEn", PAR_Calc_en, 0);
    checkOutput("rst_lat", P_DATA_lat, 0);
    checkOutput("rst_typLat", PAR_TYP_lat, 0);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checkOutput("quiet_tx", TX_OUT, 1);
      checkOutput("quiet_busy", Busy, 0);
    end

    // Back-to-back directed frames, including ignored strobes mid-frame and in STOP.
    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset during the 5th data bit aborts before the next clock edge.
    @(negedge CLK);
    Data_Valid = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      checkOutput($sformatf("abort_tx%0d", i), TX_OUT, vecs[0].seq[i]);
    end
    #2 RST = 1'b0;
    #1;
    checkOutput("abort_tx", TX_OUT, 1);
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_calcEn", PAR_Calc_en, 0);
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(vecs[0]);

    // Randomised traffic against a frame-level model.
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    latData = '0;
    latTyp  = 1'b0;
    modelQ.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      expBusy = (modelQ.size() != 0);
      expTx   = expBusy ? modelQ[0] : 1'b1;
      checkOutput("rand_tx", TX_OUT, expTx);
      checkOutput("rand_busy", Busy, expBusy);
      checkOutput("rand_calcEn", PAR_Calc_en, expBusy);
      checkOutput("rand_lat", P_DATA_lat, latData);
      checkOutput("rand_typLat", PAR_TYP_lat, latTyp);
      accept = !expBusy;
      if (expBusy) void'(modelQ.pop_front());
      rDv   = ($urandom_range(0, 3) == 0);
      rData = 8'($urandom);
      rEn   = 1'($urandom);
      rTyp  = 1'($urandom);
      parJunk    = 1'($urandom);
      Data_Valid = rDv;
      P_DATA     = rData;
      PAR_EN     = rEn;
      PAR_TYP    = rTyp;
      if (rDv && accept) begin
        latData = rData;
        latTyp  = rTyp;
        ones    = $countones(rData);
        modelQ.push_back(1'b0);
        for (int b = 0; b < DW; b++) modelQ.push_back(rData[b]);
        if (rEn) modelQ.push_back(rTyp ? (ones % 2 == 0) : (ones % 2 == 1));
        modelQ.push_back(1'b1);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
